dram_timing_ctrl: RTL and testbench

- Timing sequencer for the DRAM command FSM.
- Watches the FSM's current command state, times each DRAM command phase, and returns the per-phase done strobes (tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done) that advance the FSM.
- Also owns the periodic refresh interval and raises rf_req, tracking up to 8 postponed refreshes.
- Sits beside the command FSM inside the DRAM controller; connects through the timing-side view of the command FSM interface plus init_done.

---
 rtl/dram_pkg.sv | 31 +++
 rtl/dram_refresh_timer.sv | 59 +++++
 rtl/dram_timing_ctrl.sv | 107 ++++++++++
 tb/tb_dram_timing_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM command states and default timing constants
package dram_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ACTIVATE   = 4'd1,
        READ       = 4'd2,
        WRITE      = 4'd3,
        PRECHARGE  = 4'd4,
        REFRESH    = 4'd5,
        INIT_WAIT  = 4'd6,
        INIT_PRE   = 4'd7,
        INIT_REF   = 4'd8,
        INIT_MRS   = 4'd9
    } dram_state_t;

    localparam int DEFAULT_TRCD     = 4;
    localparam int DEFAULT_TRP      = 4;
    localparam int DEFAULT_TCL      = 5;
    localparam int DEFAULT_TCWL     = 4;
    localparam int DEFAULT_TBURST   = 4;
    localparam int DEFAULT_TWR      = 4;
    localparam int DEFAULT_TRFC     = 26;
    localparam int DEFAULT_TREFI    = 780;
    localparam int DEFAULT_MAX_PEND = 8;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - refresh interval counter and postponed-refresh tracking
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int tREFI    = DEFAULT_TREFI,
    parameter int MAX_PEND = DEFAULT_MAX_PEND
) (
    input  logic CLK,
    input  logic nRST,
    input  logic init_done,
    input  logic refDone,
    output logic rf_req,
    output logic rf_urgent
);

    localparam int IW = $clog2(tREFI);
    localparam int PW = $clog2(MAX_PEND + 1);

    generate
        if (tREFI < 2 || MAX_PEND < 1) begin : gBadRefreshParams
            $error("dram_refresh_timer: tREFI must be >= 2 and MAX_PEND >= 1");
        end
    endgenerate

    logic [IW-1:0] ivalCnt;
    logic [PW-1:0] pendCnt;
    logic          wrap;

    assign wrap = init_done && (ivalCnt == IW'(tREFI - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ivalCnt <= '0;
        end else if (!init_done || wrap) begin
            ivalCnt <= '0;
        end else begin
            ivalCnt <= ivalCnt + IW'(1);
        end
    end

    // A new request and a serviced refresh in the same cycle cancel out.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pendCnt <= '0;
        end else if (wrap && !refDone) begin
            if (pendCnt != PW'(MAX_PEND)) begin
                pendCnt <= pendCnt + PW'(1);
            end
        end else if (refDone && !wrap) begin
            if (pendCnt != '0) begin
                pendCnt <= pendCnt - PW'(1);
            end
        end
    end

    assign rf_req    = (pendCnt != '0);
    assign rf_urgent = (pendCnt == PW'(MAX_PEND));

endmodule

// File: rtl/dram_timing_ctrl.sv
// rtl/dram_timing_ctrl.sv - per-phase timing and done strobes for the DRAM command FSM
module dram_timing_ctrl
    import dram_pkg::*;
#(
    parameter int tRCD     = DEFAULT_TRCD,
    parameter int tRP      = DEFAULT_TRP,
    parameter int tCL      = DEFAULT_TCL,
    parameter int tCWL     = DEFAULT_TCWL,
    parameter int tBURST   = DEFAULT_TBURST,
    parameter int tWR      = DEFAULT_TWR,
    parameter int tRFC     = DEFAULT_TRFC,
    parameter int tREFI    = DEFAULT_TREFI,
    parameter int MAX_PEND = DEFAULT_MAX_PEND
) (
    input  logic        CLK,
    input  logic        nRST,
    input  dram_state_t cmd_state,
    input  logic        init_done,
    output logic        tACT_done,
    output logic        tRD_done,
    output logic        tWR_done,
    output logic        tPRE_done,
    output logic        tREF_done,
    output logic        rf_req,
    output logic        rf_urgent
);

    localparam int nAct = tRCD;
    localparam int nRd  = tCL + tBURST;
    localparam int nWr  = tCWL + tBURST + tWR;
    localparam int nPre = tRP;
    localparam int nRef = tRFC;
    localparam int nMax = maxInt(maxInt(maxInt(nAct, nRd), maxInt(nWr, nPre)), nRef);
    localparam int CW   = $clog2(nMax) + 1;

    generate
        if (nAct < 1 || nRd < 1 || nWr < 1 || nPre < 1 || nRef < 1) begin : gBadLimit
            $error("dram_timing_ctrl: every phase limit must be at least 1 cycle");
        end
    endgenerate

    dram_state_t   prevState;
    logic [CW-1:0] phaseCnt;
    logic [CW-1:0] curCnt;
    logic [CW-1:0] limM1;
    logic          timed;
    logic          atLimit;
    logic          refDoneQ;
    logic          refExit;

    always_comb begin
        timed = 1'b1;
        limM1 = '0;
        case (cmd_state)
            ACTIVATE:  limM1 = CW'(nAct - 1);
            READ:      limM1 = CW'(nRd - 1);
            WRITE:     limM1 = CW'(nWr - 1);
            PRECHARGE: limM1 = CW'(nPre - 1);
            REFRESH:   limM1 = CW'(nRef - 1);
            default:   timed = 1'b0;
        endcase
    end

    // The entry cycle of a phase is count 0, whatever the register still holds.
    assign curCnt  = (cmd_state != prevState) ? '0 : phaseCnt;
    assign atLimit = nRST && timed && (curCnt == limM1);

    assign tACT_done = atLimit && (cmd_state == ACTIVATE);
    assign tRD_done  = atLimit && (cmd_state == READ);
    assign tWR_done  = atLimit && (cmd_state == WRITE);
    assign tPRE_done = atLimit && (cmd_state == PRECHARGE);
    assign tREF_done = atLimit && (cmd_state == REFRESH);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prevState <= IDLE;
            phaseCnt  <= '0;
            refDoneQ  <= 1'b0;
        end else begin
            prevState <= cmd_state;
            refDoneQ  <= tREF_done;
            if (!timed) begin
                phaseCnt <= '0;
            end else if (curCnt == limM1) begin
                phaseCnt <= curCnt;
            end else begin
                phaseCnt <= curCnt + CW'(1);
            end
        end
    end

    // Only a completed REFRESH that is then left counts as serviced.
    assign refExit = refDoneQ && (cmd_state != REFRESH);

    dram_refresh_timer #(
        .tREFI    (tREFI),
        .MAX_PEND (MAX_PEND)
    ) uRefreshTimer (
        .CLK       (CLK),
        .nRST      (nRST),
        .init_done (init_done),
        .refDone   (refExit),
        .rf_req    (rf_req),
        .rf_urgent (rf_urgent)
    );

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// tb/tb_dram_timing_ctrl.sv - randomized and directed bench for dram_timing_ctrl
module tb_dram_timing_ctrl;
    import dram_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    dram_state_t cmd_state = IDLE;
    logic        init_done = 1'b0;
    logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done;
    logic        rf_req, rf_urgent;

    dram_timing_ctrl dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .cmd_state (cmd_state),
        .init_done (init_done),
        .tACT_done (tACT_done),
        .tRD_done  (tRD_done),
        .tWR_done  (tWR_done),
        .tPRE_done (tPRE_done),
        .tREF_done (tREF_done),
        .rf_req    (rf_req),
        .rf_urgent (rf_urgent)
    );

    always #5 CLK = ~CLK;

    int vecCount  = 0;
    int missCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase age since entry (unbounded), refresh interval position, pending count.
    dram_state_t mPrev;
    int          mAge, mPend, mIval, curAge;

    function automatic int limOf(input dram_state_t s);
        case (s)
            ACTIVATE:  return 4;
            READ:      return 5 + 4;
            WRITE:     return 4 + 4 + 4;
            PRECHARGE: return 4;
            REFRESH:   return 26;
            default:   return 0;
        endcase
    endfunction

    function automatic bit expDone(input dram_state_t s, input dram_state_t phase, input int age);
        return (s == phase) && (limOf(s) > 0) && (age >= limOf(s) - 1);
    endfunction

    task automatic modelReset();
        mPrev = IDLE;
        mAge  = 0;
        mPend = 0;
        mIval = 0;
    endtask

    task automatic drive(input dram_state_t s, input bit init);
        cmd_state = s;
        init_done = init;
        @(negedge CLK);
        curAge = (s != mPrev) ? 0 : mAge + 1;
        checkVal("tACT_done", tACT_done, expDone(s, ACTIVATE, curAge));
        checkVal("tRD_done",  tRD_done,  expDone(s, READ, curAge));
        checkVal("tWR_done",  tWR_done,  expDone(s, WRITE, curAge));
        checkVal("tPRE_done", tPRE_done, expDone(s, PRECHARGE, curAge));
        checkVal("tREF_done", tREF_done, expDone(s, REFRESH, curAge));
        checkVal("rf_req",    rf_req,    mPend != 0);
        checkVal("rf_urgent", rf_urgent, mPend == 8);
    endtask

    task automatic clockEdge();
        bit inc, dec;
        inc = init_done && (mIval == 779);
        dec = (mPrev == REFRESH) && (cmd_state != REFRESH) && (mAge >= limOf(REFRESH) - 1);
        if (inc && !dec && mPend < 8) mPend++;
        else if (dec && !inc && mPend > 0) mPend--;
        mIval = !init_done ? 0 : (mIval == 779 ? 0 : mIval + 1);
        mPrev = cmd_state;
        mAge  = curAge;
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc(input dram_state_t s, input bit init);
        drive(s, init);
        clockEdge();
    endtask

    task automatic hold(input dram_state_t s, input bit init, input int n);
        for (int k = 0; k < n; k++) cyc(s, init);
    endtask

    task automatic doReset();
        nRST = 1'b0;
        #1;
        checkVal("rst_act", tACT_done, 0);
        checkVal("rst_rd",  tRD_done,  0);
        checkVal("rst_wr",  tWR_done,  0);
        checkVal("rst_pre", tPRE_done, 0);
        checkVal("rst_ref", tREF_done, 0);
        checkVal("rst_req", rf_req,    0);
        checkVal("rst_urg", rf_urgent, 0);
        @(posedge CLK);
        #1;
        modelReset();
        nRST = 1'b1;
    endtask

    dram_state_t pool [10] = '{IDLE, ACTIVATE, READ, WRITE, PRECHARGE, REFRESH,
                               INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS};

    initial begin
        #1 CLK = 1'b0;
        forever @(posedge CLK);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        modelReset();
        @(posedge CLK);
        #1;
        doReset();

        hold(IDLE, 0, 2);
        for (int i = 0; i < 6; i++) begin
            drive(ACTIVATE, 0);
            checkVal("act_cycle", tACT_done, i >= 3);
            clockEdge();
        end
        drive(IDLE, 0);
        checkVal("act_after", tACT_done, 0);
        clockEdge();

        for (int i = 0; i < 10; i++) begin
            drive(READ, 0);
            checkVal("rd_cycle", tRD_done, i >= 8);
            clockEdge();
        end
        for (int i = 0; i < 13; i++) begin
            drive(WRITE, 0);
            checkVal("wr_cycle", tWR_done, i >= 11);
            checkVal("wr_no_rd", tRD_done, 0);
            clockEdge();
        end

        for (int i = 0; i < 2; i++) begin
            drive(ACTIVATE, 0);
            checkVal("abort_act", tACT_done, 0);
            clockEdge();
        end
        for (int i = 0; i < 5; i++) begin
            drive(PRECHARGE, 0);
            checkVal("pre_cycle", tPRE_done, i >= 3);
            checkVal("abort_no_act", tACT_done, 0);
            clockEdge();
        end

        for (int i = 0; i <= 6240; i++) begin
            drive(IDLE, 1);
            if (i == 779 || i == 780) checkVal("rf_req_rise", rf_req, i == 780);
            if (i == 6239 || i == 6240) checkVal("rf_urgent_rise", rf_urgent, i == 6240);
            clockEdge();
        end
        hold(IDLE, 1, 1600);
        drive(IDLE, 1);
        checkVal("urgent_sat", rf_urgent, 1);
        clockEdge();

        doReset();
        hold(IDLE, 1, 1560);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 26; i++) begin
                drive(REFRESH, 1);
                checkVal("ref_cycle", tREF_done, i == 25);
                clockEdge();
            end
            cyc(IDLE, 1);
            drive(IDLE, 1);
            checkVal("ref_service_req", rf_req, r == 0);
            clockEdge();
        end

        guard = 0;
        while (mPend == 0 && guard < 2000) begin
            cyc(IDLE, 1);
            guard++;
        end
        while (mIval != 753 && guard < 4000) begin
            cyc(IDLE, 1);
            guard++;
        end
        hold(REFRESH, 1, 26);
        cyc(IDLE, 1);
        drive(IDLE, 1);
        checkVal("coincident_req", rf_req, 1);
        clockEdge();

        for (int i = 0; i < 9; i++) begin
            drive(READ, 1);
            checkVal("rd_pre_rst", tRD_done, i == 8);
            if (i < 8) clockEdge();
        end
        doReset();
        for (int i = 0; i < 10; i++) begin
            drive(READ, 1);
            checkVal("rd_post_rst", tRD_done, i >= 8);
            clockEdge();
        end

        repeat (220) begin
            dram_state_t s;
            bit          init;
            int          len;
            s    = pool[$urandom_range(0, 9)];
            init = ($urandom_range(0, 9) != 0);
            len  = $urandom_range(1, 30);
            hold(s, init, len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
